mem_responder: RTL
==================

# mem_responder

Memory-side responder for the CPU's RAM interface: it answers the access requests the control unit issues through MCS and MRW, and sits between the MAR/data path and the RAM array. It latches each request, inserts a configurable number of wait states, then performs the read or write. It signals completion with a one-cycle ready pulse that the control unit uses to stretch its t-states. A side-band loader port fills program memory before the CPU runs.

## Interface
- DBus, 5, data word width (matches instruction/data width)
- ABus, 5, address width; depth = 2**ABus words
- WAIT, 1, wait states inserted per access (0..15)

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MCS  in  1  chip select, active-low
- MRW  in  1  0 = read, 1 = write
- MSTB  in  1  one-cycle access strobe; qualified by MCS==0
- addr  in  ABus  access address (MAR output)
- din  in  DBus  write data
- dout  out  DBus  registered read data
- MRDY  out  1  access-complete pulse
- MBUSY  out  1  high while an access is in flight
- MERR  out  1  sticky protocol-error flag
- ld_we  in  1  loader write enable
- ld_addr  in  ABus  loader address
- ld_data  in  DBus  loader data

## Operation
- FSM states: IDLE, WAITS, DONE.
- IDLE: an access starts when MSTB=1 and MCS=0 at a clock edge. That edge latches addr, MRW and din into addr_q, rw_q and din_q. It also loads the counter with WAIT. Next state is WAITS if WAIT>0, otherwise DONE.
- WAITS: the counter decrements each cycle. When the counter is 1, next state is DONE.
- DONE, read (rw_q=0): dout <= array[addr_q].
- DONE, write (rw_q=1): array[addr_q] <= din_q. dout holds its previous value.
- DONE: MRDY=1 for exactly this cycle. Next state is always IDLE.
- MBUSY=1 in WAITS and DONE.
- MSTB while not in IDLE: the strobe is ignored and MERR is set. The in-flight access is unaffected.
- MSTB with MCS=1: ignored. MERR is not set.
- Loader: ld_we writes array[ld_addr] <= ld_data. It is accepted only in IDLE with no qualified MSTB in the same cycle.
  - ld_we in any other case: the write is dropped and MERR is set.
- MERR clears only on reset.
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, dout=0, MRDY=0, MBUSY=0, MERR=0.
  - addr_q, din_q and rw_q are cleared.
  - The array is not reset; its contents are retained.
  - An in-flight write that has not reached DONE is discarded.
- Address arithmetic is modulo 2**ABus (no out-of-range condition).
- The counter is 4 bits wide.

## Timing
- Strobe sampled at edge k: MRDY is high during cycle k+WAIT+1.
- Read data is valid on dout from that same edge and holds until the next read completes.
- Write: array updated at the edge ending DONE. A read issued after MRDY returns the new value.
- Back-to-back: the next MSTB is accepted at the edge immediately after the DONE cycle (IDLE). Throughput is one access per WAIT+2 cycles.
- WAIT=0: strobe at k, MRDY in cycle k+1.
- Reset deassertion is synchronised by the caller. The first accepted strobe is the edge after reset goes high.
- All outputs are registered. None is combinationally dependent on inputs.

## Structure
- Package mem_pkg:
  - state encoding constants: IDLE=0, WAITS=1, DONE=2.
  - MRW_READ=0, MRW_WRITE=1.
  - default DBus/ABus widths, shared with the control unit.
- Sub-module mem_array: storage of 2**ABus x DBus words.
  - One synchronous write port, muxed between DONE-write and the loader.
  - One asynchronous read port.
  - No reset.
- FSM, counter, latches and error flag live in mem_responder.

## Test plan
- Load then read: loader writes 5'h03 to addr 1. With WAIT=2, MCS=0, MRW=0, addr=1, MSTB at edge k -> MRDY in cycle k+3, dout=5'h03, MBUSY high for cycles k+1..k+3.
- Write then read: write din=5'h1A to addr 7 with WAIT=0 -> MRDY in cycle k+1. A following read of addr 7 -> dout=5'h1A. dout is unchanged during the write.
- Overrun: second MSTB during WAITS -> MERR=1. The first access completes with correct data, and only one MRDY pulse is produced.
- Gating: MSTB with MCS=1 -> no MBUSY, no MRDY, MERR=0. Loader write during WAITS -> array unchanged at that address, MERR=1.
- Reset mid-write: assert reset during WAITS of a write of 5'h0F to addr 2, whose old value is 5'h04 -> all outputs 0 immediately. A later read of addr 2 returns 5'h04.
- Back-to-back reads of addr 0 and addr 1 with WAIT=1 -> MRDY pulses exactly 3 cycles apart, with correct dout each time.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RAM responder: default bus widths, responder state
// encoding and MRW polarity. The control unit uses the same widths.
package mem_pkg;

  localparam int DBUS_W = 5;
  localparam int ABUS_W = 5;
  localparam int CNT_W  = 4;

  localparam logic MRW_READ  = 1'b0;
  localparam logic MRW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITS = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// RAM storage for the responder: one synchronous write port and one
// asynchronous read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int DBUS = DBUS_W,
  parameter int ABUS = ABUS_W
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [ABUS-1:0] i_waddr,
  input  logic [DBUS-1:0] i_wdata,
  input  logic [ABUS-1:0] i_raddr,
  output logic [DBUS-1:0] o_rdata
);

  logic [DBUS-1:0] r_mem [0:(1<<ABUS)-1];

  // NOTE: the array has no reset on purpose; program memory survives a CPU reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches an MCS/MSTB request, waits WAIT cycles, then
// reads or writes the array and pulses MRDY for one cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DBUS = DBUS_W,
  parameter int          ABUS = ABUS_W,
  parameter int unsigned WAIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_mcs,
  input  logic            i_mrw,
  input  logic            i_mstb,
  input  logic [ABUS-1:0] i_addr,
  input  logic [DBUS-1:0] i_din,
  output logic [DBUS-1:0] o_dout,
  output logic            o_mrdy,
  output logic            o_mbusy,
  output logic            o_merr,
  input  logic            i_ld_we,
  input  logic [ABUS-1:0] i_ld_addr,
  input  logic [DBUS-1:0] i_ld_data
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ABUS-1:0]   r_addr_q;
  logic [DBUS-1:0]   r_din_q, r_dout;
  logic              r_rw_q, r_mrdy, r_mbusy, r_merr;

  logic              w_strobe, w_accept, w_ld_ok, w_done_wr, w_we, w_rd_now;
  logic [ABUS-1:0]   w_rd_addr, w_wr_addr;
  logic [DBUS-1:0]   w_wr_data, w_rdata;

  assign w_strobe = i_mstb & ~i_mcs;
  assign w_accept = w_strobe & (r_state == IDLE);
  assign w_ld_ok  = i_ld_we & (r_state == IDLE) & ~w_strobe;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  // Read data is captured on the edge entering DONE, so dout is valid while MRDY is high;
  // with no wait states that edge is the accepting one, hence the live address/MRW.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_now    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CNT == '0) begin
            w_state_nxt = DONE;
            w_rd_now    = (i_mrw == MRW_READ);
          end else begin
            w_state_nxt = WAITS;
          end
        end
      end
      WAITS: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
          w_rd_now    = (r_rw_q == MRW_READ);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_addr = (r_state == IDLE) ? i_addr : r_addr_q;
  assign w_done_wr = (r_state == DONE) & (r_rw_q == MRW_WRITE);
  assign w_we      = w_done_wr | w_ld_ok;
  assign w_wr_addr = w_done_wr ? r_addr_q : i_ld_addr;
  assign w_wr_data = w_done_wr ? r_din_q  : i_ld_data;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr_q <= '0;
      r_din_q  <= '0;
      r_rw_q   <= MRW_READ;
      r_dout   <= '0;
      r_mrdy   <= 1'b0;
      r_mbusy  <= 1'b0;
      r_merr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mrdy  <= (w_state_nxt == DONE);
      r_mbusy <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_addr_q <= i_addr;
        r_din_q  <= i_din;
        r_rw_q   <= i_mrw;
        r_cnt    <= WAIT_CNT;
      end else if (r_state == WAITS) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_rd_now) r_dout <= w_rdata;
      if ((w_strobe && (r_state != IDLE)) || (i_ld_we && !w_ld_ok)) r_merr <= 1'b1;
    end
  end

  mem_array #(
    .DBUS (DBUS),
    .ABUS (ABUS)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  assign o_dout  = r_dout;
  assign o_mrdy  = r_mrdy;
  assign o_mbusy = r_mbusy;
  assign o_merr  = r_merr;

endmodule
